// File: rtl/scalar_seq_ctrl_pkg.sv
// Shared constants for the scalar micro-sequencer and the scalar PE.
// Opcodes, data width and the instruction-word layout helper.
package scalar_seq_ctrl_pkg;

  localparam int DW = 32;

  localparam logic [2:0] OP_LUI  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_NOP  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  // op | rd | rs1 | rs2 | tgt | imm
  function automatic int instr_w(input int aw, input int rw);
    return 3 + 3 * rw + aw + DW;
  endfunction

endpackage

// File: rtl/scalar_seq_ctrl_if.sv
// Host, program-load and scalar-PE signals of the sequencer.
// master = sequencer side, slave = environment side.
interface scalar_seq_ctrl_if #(
  parameter int IMEM_DEPTH = 16,
  parameter int NREG       = 8
);
  import scalar_seq_ctrl_pkg::*;

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NREG);
  localparam int IW = instr_w(AW, RW);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          abort;
  logic [DW-1:0] pe_inp1;
  logic [DW-1:0] pe_inp2;
  logic [DW-1:0] pe_imm;
  logic [2:0]    pe_op;
  logic [DW-1:0] pe_out1;
  logic          pe_flag_eq;
  logic [RW-1:0] rd_sel;
  logic [DW-1:0] rd_data;

  modport master (
    input  prog_we, prog_addr, prog_data, start,
    input  pe_out1, pe_flag_eq, rd_sel,
    output busy, done, abort,
    output pe_inp1, pe_inp2, pe_imm, pe_op,
    output rd_data
  );

  modport slave (
    output prog_we, prog_addr, prog_data, start,
    output pe_out1, pe_flag_eq, rd_sel,
    input  busy, done, abort,
    input  pe_inp1, pe_inp2, pe_imm, pe_op,
    input  rd_data
  );

endinterface

// File: rtl/scalar_seq_ctrl_regfile.sv
// Scalar register file: one write port, two registered reads
// feeding the PE operands, one combinational debug read.
module scalar_seq_ctrl_regfile
  import scalar_seq_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [RW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic          re_i,
  input  logic [RW-1:0] ra1_i,
  input  logic [RW-1:0] ra2_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o,
  input  logic [RW-1:0] dbg_sel_i,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (we_i) begin
        regs_q[wa_i] <= wd_i;
      end
      if (re_i) begin
        rd1_q <= regs_q[ra1_i];
        rd2_q <= regs_q[ra2_i];
      end
    end
  end

  assign rd1_o      = rd1_q;
  assign rd2_o      = rd2_q;
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/scalar_seq_ctrl.sv
// Micro-sequencer for the CGRA scalar PE: loadable program,
// two-cycle fetch/exec, branch on PE equality, step watchdog.
module scalar_seq_ctrl
  import scalar_seq_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int NREG       = 8,
  parameter int MAX_STEPS  = 1024
) (
  input logic               clk,
  input logic               rst_n,
  scalar_seq_ctrl_if.master bus
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NREG);
  localparam int IW = instr_w(AW, RW);
  localparam int SW = $clog2(MAX_STEPS + 1);

  localparam int TGT_LSB = DW;
  localparam int RS2_LSB = TGT_LSB + AW;
  localparam int RS1_LSB = RS2_LSB + RW;
  localparam int RD_LSB  = RS1_LSB + RW;
  localparam int OP_LSB  = RD_LSB + RW;

  localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEPS);
  localparam logic [AW-1:0] PC_LAST  = AW'(IMEM_DEPTH - 1);

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [SW-1:0] steps_q;
  logic [RW-1:0] ir_rd_q;
  logic [AW-1:0] ir_tgt_q;
  logic [2:0]    pe_op_q;
  logic [DW-1:0] pe_imm_q;
  logic          busy_q;
  logic          done_q;
  logic          abort_q;

  logic [IW-1:0] imem_q [IMEM_DEPTH];
  logic [IW-1:0] fw;
  logic [SW-1:0] step_d;
  logic          in_exec;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          taken;
  logic          wdog_d;
  logic          fin_d;

  // Program store is deliberately not reset; it survives rst_n.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state_q == S_IDLE) begin
      imem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign fw      = imem_q[pc_q];
  assign in_exec = (state_q == S_EXEC);
  assign step_d  = steps_q + SW'(1);
  assign wdog_d  = (step_d == STEP_MAX);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = pe_imm_q;
    taken   = 1'b0;
    unique case (1'b1)
      pe_op_q == OP_LUI:  wr_en = in_exec;
      pe_op_q == OP_ADDI: begin
        wr_en   = in_exec;
        wr_data = bus.pe_out1;
      end
      pe_op_q == OP_BEQ:  taken = bus.pe_flag_eq;
      default: ;
    endcase
  end

  assign fin_d = wdog_d || pe_op_q == OP_HALT
              || (!taken && pc_q == PC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      steps_q  <= '0;
      ir_rd_q  <= '0;
      ir_tgt_q <= '0;
      pe_op_q  <= OP_NOP;
      pe_imm_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            steps_q <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_rd_q  <= fw[RD_LSB +: RW];
          ir_tgt_q <= fw[TGT_LSB +: AW];
          pe_op_q  <= fw[OP_LSB +: 3];
          pe_imm_q <= fw[DW-1:0];
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          steps_q <= step_d;
          pe_op_q <= OP_NOP;
          if (fin_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            abort_q <= wdog_d;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= taken ? ir_tgt_q : pc_q + AW'(1);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  scalar_seq_ctrl_regfile #(
    .NREG(NREG)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wr_en),
    .wa_i      (ir_rd_q),
    .wd_i      (wr_data),
    .re_i      (state_q == S_FETCH),
    .ra1_i     (fw[RS1_LSB +: RW]),
    .ra2_i     (fw[RS2_LSB +: RW]),
    .rd1_o     (bus.pe_inp1),
    .rd2_o     (bus.pe_inp2),
    .dbg_sel_i (bus.rd_sel),
    .dbg_data_o(bus.rd_data)
  );

  assign bus.pe_op  = pe_op_q;
  assign bus.pe_imm = pe_imm_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.abort  = abort_q;

endmodule

// File: tb/tb_scalar_seq_ctrl.sv
// Bench for scalar_seq_ctrl: directed programs plus random
// programs checked against an instruction-level interpreter.
module tb_scalar_seq_ctrl;

  localparam int MAXS = 20;

  logic clk;
  logic rst_n;
  int   total;
  int   npass;

  logic [47:0] mem_m [16];
  logic [31:0] reg_m [8];

  scalar_seq_ctrl_if #(.IMEM_DEPTH(16), .NREG(8)) bus ();

  scalar_seq_ctrl #(
    .IMEM_DEPTH(16),
    .NREG      (8),
    .MAX_STEPS (MAXS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar PE stand-in: adds for ADDI, zero otherwise.
  always_comb begin
    bus.pe_out1    = '0;
    bus.pe_flag_eq = (bus.pe_inp1 == bus.pe_inp2);
    if (bus.pe_op == 3'b001) bus.pe_out1 = bus.pe_inp1 + bus.pe_imm;
  end

  function automatic logic [47:0] enc(
    input logic [2:0] op, input logic [2:0] rd,
    input logic [2:0] rs1, input logic [2:0] rs2,
    input logic [3:0] tg, input logic [31:0] im);
    return {op, rd, rs1, rs2, tg, im};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic model_run(output int n, output bit ab);
    int pc;
    logic [47:0] w;
    logic [2:0] op;
    int rd, rs1, rs2, tg;
    logic [31:0] im;
    pc = 0; n = 0; ab = 0;
    forever begin
      w = mem_m[pc];
      op = w[47:45];
      rd = int'(w[44:42]);
      rs1 = int'(w[41:39]);
      rs2 = int'(w[38:36]);
      tg = int'(w[35:32]);
      im = w[31:0];
      n++;
      if (op == 3'b000) reg_m[rd] = im;
      else if (op == 3'b001) reg_m[rd] = reg_m[rs1] + im;
      if (n == MAXS) begin ab = 1; break; end
      if (op == 3'b111) break;
      if (op == 3'b010 && reg_m[rs1] == reg_m[rs2]) pc = tg;
      else if (pc == 15) break;
      else pc++;
    end
  endtask

  task automatic load(input int a, input logic [47:0] d);
    @(negedge clk);
    bus.prog_we = 1'b1;
    bus.prog_addr = 4'(a);
    bus.prog_data = d;
    mem_m[a] = d;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.rd_sel = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), bus.rd_data, reg_m[i]);
    end
  endtask

  task automatic run(input string tag, input bit drop_wr,
                     input bit wr0, input logic [47:0] w0);
    int steps, c, busyc;
    bit ab, seen;
    logic [2:0] op0;
    @(negedge clk);
    bus.start = 1'b1;
    if (wr0) begin
      bus.prog_we = 1'b1;
      bus.prog_addr = 4'd0;
      bus.prog_data = w0;
      mem_m[0] = w0;
    end
    op0 = mem_m[0][47:45];
    model_run(steps, ab);
    @(negedge clk);
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    c = 1; busyc = 0; seen = 0;
    chk({tag, "_abort_clr"}, {31'd0, bus.abort}, 32'd0);
    while (c < 2 * MAXS + 10) begin
      if (bus.done) begin seen = 1; break; end
      if (bus.busy) busyc++;
      if (c == 2) chk({tag, "_pe_op"}, {29'd0, bus.pe_op}, {29'd0, op0});
      if (drop_wr) begin
        bus.prog_we = 1'b1;
        bus.prog_addr = 4'($urandom_range(0, 15));
        bus.prog_data = {$urandom, $urandom};
      end
      @(negedge clk);
      c++;
    end
    bus.prog_we = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_done_cyc"}, c, 1 + 2 * steps);
    chk({tag, "_busy_cyc"}, busyc, 2 * steps);
    chk({tag, "_abort"}, {31'd0, bus.abort}, {31'd0, ab});
    chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    chk_regs(tag);
  endtask

  initial begin
    logic [47:0] hlt, nop;
    logic [2:0] o;
    int r;
    total = 0; npass = 0;
    rst_n = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.rd_sel = '0;
    for (int i = 0; i < 8; i++) reg_m[i] = '0;
    hlt = enc(3'b111, 0, 0, 0, 0, 0);
    nop = enc(3'b011, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_pe_op", {29'd0, bus.pe_op}, 32'd3);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_abort", {31'd0, bus.abort}, 32'd0);
    chk("rst_inp1", bus.pe_inp1, 32'd0);
    chk("rst_imm", bus.pe_imm, 32'd0);
    chk_regs("rst");

    for (int i = 0; i < 16; i++) load(i, hlt);
    run("halt", 0, 0, '0);

    load(0, enc(3'b000, 1, 0, 0, 0, 5));
    load(1, enc(3'b001, 2, 1, 0, 0, 7));
    load(2, hlt);
    run("lui_addi", 0, 0, '0);

    load(0, enc(3'b000, 1, 0, 0, 0, 0));
    load(1, enc(3'b000, 2, 0, 0, 0, 3));
    load(2, enc(3'b001, 1, 1, 0, 0, 1));
    load(3, enc(3'b010, 0, 1, 2, 5, 0));
    load(4, enc(3'b010, 0, 0, 0, 2, 0));
    load(5, hlt);
    run("loop", 0, 0, '0);

    load(0, enc(3'b000, 1, 0, 0, 0, 32'hFFFF_FFFF));
    load(1, enc(3'b001, 1, 1, 0, 0, 1));
    load(2, hlt);
    run("wrap", 0, 0, '0);

    for (int i = 0; i < 16; i++) load(i, nop);
    run("nops", 0, 0, '0);

    load(0, enc(3'b010, 0, 0, 0, 0, 0));
    run("wdog", 0, 0, '0);
    repeat (3) @(negedge clk);
    chk("wdog_abort_hold", {31'd0, bus.abort}, 32'd1);

    load(1, hlt);
    run("same_cyc", 0, 1, enc(3'b000, 3, 0, 0, 0, 77));

    load(0, enc(3'b000, 1, 0, 0, 0, 0));
    load(1, enc(3'b000, 2, 0, 0, 0, 3));
    load(2, enc(3'b001, 1, 1, 0, 0, 1));
    load(3, enc(3'b010, 0, 1, 2, 5, 0));
    load(4, enc(3'b010, 0, 0, 0, 2, 0));
    load(5, hlt);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_pe_op", {29'd0, bus.pe_op}, 32'd3);
    for (int i = 0; i < 8; i++) reg_m[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run("rerun", 0, 0, '0);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 9);
        o = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 :
            (r < 8) ? 3'b010 : (r == 8) ? 3'b011 : 3'b111;
        load(i, enc(o, 3'($urandom), 3'($urandom),
                    3'($urandom), 4'($urandom),
                    (r < 3) ? 32'($urandom_range(0, 3))
                            : $urandom));
      end
      run($sformatf("rnd%0d", t), 1, 0, '0);
    end

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
